// File: rtl/pkg_cpu.sv
// CPU-wide types: ALU opcode enum, ALU port structs, and the request/response
// records used by the ALU sharing controller.
package pkg_cpu;

    localparam int CPU_WORD_WIDTH                 = 32;
    localparam int CPU_ENUM_ALU_OPER_SIZE_MSB_POS = 3;
    localparam int CPU_FLAGS_WIDTH                = 4;
    localparam int ALU_NUM_REQ                    = 2;

    // Bit positions inside the flags word
    localparam int FlagC = 0;
    localparam int FlagZ = 1;
    localparam int FlagV = 2;
    localparam int FlagN = 3;

    typedef logic [CPU_WORD_WIDTH-1:0]  cpu_word_t;
    typedef logic [CPU_FLAGS_WIDTH-1:0] cpu_flags_t;

    typedef enum logic [CPU_ENUM_ALU_OPER_SIZE_MSB_POS:0] {
        Alu_Add = 4'd0,
        Alu_Sub = 4'd1,
        Alu_And = 4'd2,
        Alu_Or  = 4'd3,
        Alu_Xor = 4'd4,
        Alu_Rol = 4'd5,
        Alu_Ror = 4'd6,
        Alu_Rlc = 4'd7,
        Alu_Rrc = 4'd8
    } alu_oper_e;

    typedef struct packed {
        cpu_word_t  a;
        cpu_word_t  b;
        alu_oper_e  oper;
        cpu_flags_t flags_in;
    } StrcInAlu;

    typedef struct packed {
        cpu_word_t  out;
        cpu_flags_t flags_out;
    } StrcOutAlu;

    typedef struct packed {
        cpu_word_t  a;
        cpu_word_t  b;
        alu_oper_e  oper;
        logic       upd_flags;
    } StrcAluReq;

    typedef struct packed {
        cpu_word_t  out;
        cpu_flags_t flags;
    } StrcAluRsp;

    // Packs individual flag bits into their architectural positions
    function automatic cpu_flags_t make_flags(input logic n, input logic v,
                                              input logic z, input logic c);
        cpu_flags_t f;
        f        = '0;
        f[FlagN] = n;
        f[FlagV] = v;
        f[FlagZ] = z;
        f[FlagC] = c;
        return f;
    endfunction

endpackage

// File: rtl/Alu.sv
// Combinational ALU. Carry is "no borrow" on subtract; logic ops and plain
// rotates keep C/V from flags_in, Rlc/Rrc rotate one bit through carry.
module Alu
    import pkg_cpu::*;
(
    input  StrcInAlu  i_alu,
    output StrcOutAlu o_alu
);

    localparam int W   = CPU_WORD_WIDTH;
    localparam int SHW = $clog2(CPU_WORD_WIDTH);

    logic [W-1:0]   w_res;
    logic [W:0]     w_wide;
    logic [2*W-1:0] w_rot;
    logic           w_c;
    logic           w_v;
    logic [SHW-1:0] w_sh;

    assign w_sh = i_alu.b[SHW-1:0];

    // Opcode decode and flag generation
    always_comb begin
        w_res  = '0;
        w_wide = '0;
        w_rot  = '0;
        w_c    = i_alu.flags_in[FlagC];
        w_v    = i_alu.flags_in[FlagV];
        case (i_alu.oper)
            Alu_Add: begin
                w_wide = {1'b0, i_alu.a} + {1'b0, i_alu.b};
                w_res  = w_wide[W-1:0];
                w_c    = w_wide[W];
                w_v    = (i_alu.a[W-1] == i_alu.b[W-1]) && (w_res[W-1] != i_alu.a[W-1]);
            end
            Alu_Sub: begin
                w_wide = {1'b0, i_alu.a} - {1'b0, i_alu.b};
                w_res  = w_wide[W-1:0];
                w_c    = !w_wide[W];
                w_v    = (i_alu.a[W-1] != i_alu.b[W-1]) && (w_res[W-1] != i_alu.a[W-1]);
            end
            Alu_And: w_res = i_alu.a & i_alu.b;
            Alu_Or:  w_res = i_alu.a | i_alu.b;
            Alu_Xor: w_res = i_alu.a ^ i_alu.b;
            Alu_Rol: begin
                w_rot = {i_alu.a, i_alu.a} << w_sh;
                w_res = w_rot[2*W-1:W];
            end
            Alu_Ror: begin
                w_rot = {i_alu.a, i_alu.a} >> w_sh;
                w_res = w_rot[W-1:0];
            end
            Alu_Rlc: begin
                w_res = {i_alu.a[W-2:0], i_alu.flags_in[FlagC]};
                w_c   = i_alu.a[W-1];
            end
            Alu_Rrc: begin
                w_res = {i_alu.flags_in[FlagC], i_alu.a[W-1:1]};
                w_c   = i_alu.a[0];
            end
            default: ;
        endcase
    end

    assign o_alu = '{out: w_res, flags_out: make_flags(w_res[W-1], w_v, (w_res == '0), w_c)};

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: a lone eligible requester wins, a tie goes to
// the requester that did not win last.
module rr_arb2 (
    input  logic [1:0] i_elig,
    input  logic       i_last_grant,
    output logic [1:0] o_grant
);

    // One-hot grant selection
    always_comb begin
        o_grant = 2'b00;
        case (i_elig)
            2'b01:   o_grant = 2'b01;
            2'b10:   o_grant = 2'b10;
            2'b11:   o_grant = i_last_grant ? 2'b01 : 2'b10;
            default: o_grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one ALU between the execute unit (0) and address/aux unit (1).
// Requests are arbitrated round-robin into a one-deep issue stage; the ALU
// executes from that stage and the result lands in the owner's response buffer.
module alu_share_ctrl
    import pkg_cpu::*;
#(
    parameter int WORD_WIDTH  = CPU_WORD_WIDTH,
    parameter int OPER_WIDTH  = CPU_ENUM_ALU_OPER_SIZE_MSB_POS + 1,
    parameter int FLAGS_WIDTH = CPU_FLAGS_WIDTH
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [1:0]                        req_valid,
    output logic [1:0]                        req_ready,
    input  logic [1:0][WORD_WIDTH-1:0]        req_a,
    input  logic [1:0][WORD_WIDTH-1:0]        req_b,
    input  logic [1:0][OPER_WIDTH-1:0]        req_oper,
    input  logic [1:0]                        req_upd_flags,
    output logic [1:0]                        rsp_valid,
    input  logic [1:0]                        rsp_ready,
    output logic [1:0][WORD_WIDTH-1:0]        rsp_out,
    output logic [1:0][FLAGS_WIDTH-1:0]       rsp_flags,
    output logic [FLAGS_WIDTH-1:0]            flags_out,
    output logic                              busy
);

    logic [ALU_NUM_REQ-1:0] w_elig;
    logic [ALU_NUM_REQ-1:0] w_grant;
    logic [ALU_NUM_REQ-1:0] w_buf_valid;
    logic                   w_sel;

    StrcAluReq  r_stage;
    logic       r_stage_valid;
    logic       r_stage_owner;
    logic       r_last_grant;
    cpu_flags_t r_flags;

    StrcInAlu   w_alu_in;
    StrcOutAlu  w_alu_out;

    rr_arb2 u_arb (
        .i_elig       (w_elig),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant)
    );

    assign req_ready = w_grant;
    assign w_sel     = w_grant[1];

    // Issue stage and round-robin history; history moves only on a real grant
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stage_valid <= 1'b0;
            r_stage       <= '0;
            r_stage_owner <= 1'b0;
            r_last_grant  <= 1'b1;
        end else begin
            r_stage_valid <= |w_grant;
            if (|w_grant) begin
                r_stage.a         <= req_a[w_sel];
                r_stage.b         <= req_b[w_sel];
                r_stage.oper      <= alu_oper_e'(req_oper[w_sel]);
                r_stage.upd_flags <= req_upd_flags[w_sel];
                r_stage_owner     <= w_sel;
                r_last_grant      <= w_sel;
            end
        end
    end

    // ALU sees zeros when idle; flags_in is taken at execute so chained ops see fresh flags
    always_comb begin
        w_alu_in = '0;
        if (r_stage_valid) begin
            w_alu_in.a        = r_stage.a;
            w_alu_in.b        = r_stage.b;
            w_alu_in.oper     = r_stage.oper;
            w_alu_in.flags_in = r_flags;
        end
    end

    Alu u_alu (
        .i_alu (w_alu_in),
        .o_alu (w_alu_out)
    );

    // Architectural flags register, written only by ops that ask for it
    always_ff @(posedge clk) begin
        if (rst) begin
            r_flags <= '0;
        end else if (r_stage_valid && r_stage.upd_flags) begin
            r_flags <= w_alu_out.flags_out;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < ALU_NUM_REQ; gi++) begin : g_buf
            logic      r_valid;
            StrcAluRsp r_data;
            logic      w_hit;

            assign w_hit = r_stage_valid && (r_stage_owner == 1'(gi));

            // Result capture takes priority over drain so drain+refill keeps valid high
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_valid <= 1'b0;
                    r_data  <= '0;
                end else if (w_hit) begin
                    r_valid <= 1'b1;
                    r_data  <= '{out: w_alu_out.out, flags: w_alu_out.flags_out};
                end else if (r_valid && rsp_ready[gi]) begin
                    r_valid <= 1'b0;
                end
            end

            // One outstanding op per requester: not in the stage, buffer free or draining
            assign w_elig[gi]      = !rst && req_valid[gi] && !w_hit && !(r_valid && !rsp_ready[gi]);
            assign w_buf_valid[gi] = r_valid;
            assign rsp_out[gi]     = r_data.out;
            assign rsp_flags[gi]   = r_data.flags;
        end
    endgenerate

    assign rsp_valid = rst ? '0 : w_buf_valid;
    assign flags_out = r_flags;
    assign busy      = r_stage_valid || (|w_buf_valid);

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl: arbitration, latency, flag chaining,
// backpressure, drain/refill and mid-flight reset.
module tb_alu_share_ctrl;
    import pkg_cpu::*;

    logic             clk;
    logic             rst;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0][31:0] req_a;
    logic [1:0][31:0] req_b;
    logic [1:0][3:0]  req_oper;
    logic [1:0]       req_upd_flags;
    logic [1:0]       rsp_valid;
    logic [1:0]       rsp_ready;
    logic [1:0][31:0] rsp_out;
    logic [1:0][3:0]  rsp_flags;
    logic [3:0]       flags_out;
    logic             busy;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_alt [4];
    logic [31:0] held;

    alu_share_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_a         (req_a),
        .req_b         (req_b),
        .req_oper      (req_oper),
        .req_upd_flags (req_upd_flags),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_out       (rsp_out),
        .rsp_flags     (rsp_flags),
        .flags_out     (flags_out),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-16s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic set_req(input int k, input alu_oper_e op, input logic [31:0] a,
                           input logic [31:0] b, input logic upd);
        req_a[k]         = a;
        req_b[k]         = b;
        req_oper[k]      = op;
        req_upd_flags[k] = upd;
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_oper = '0;
        req_upd_flags = '0; rsp_ready = 2'b11;

        // Reset behaviour
        tick();
        req_valid = 2'b11; #1;
        check("rst_req_ready", 32'(req_ready), 0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        tick();
        req_valid = 2'b00; rst = 1'b0; #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_flags", 32'(flags_out), 0);
        check("rst_rsp_idle", 32'(rsp_valid), 0);

        // Tie on first cycle after reset: req0 wins, then req1
        set_req(0, Alu_Sub, 32'd7, 32'd7, 1'b1);
        set_req(1, Alu_Rol, 32'h8000_0001, 32'd4, 1'b0);
        req_valid = 2'b11; #1;
        check("tie_grant0", 32'(req_ready), 1);
        tick();
        req_valid = 2'b10; #1;
        check("tie_grant1", 32'(req_ready), 2);
        tick();
        req_valid = 2'b00; #1;
        check("tie_rsp0_valid", 32'(rsp_valid), 1);
        check("tie_rsp0_out", rsp_out[0], 0);
        check("tie_rsp0_flags", 32'(rsp_flags[0]), 3);
        check("tie_flags_reg", 32'(flags_out), 3);
        tick();
        check("tie_rsp1_valid", 32'(rsp_valid), 2);
        check("tie_rsp1_out", rsp_out[1], 32'h18);
        check("tie_rsp1_flags", 32'(rsp_flags[1]), 1);
        check("tie_flags_keep", 32'(flags_out), 3);
        tick();

        // Sustained contention alternates grants
        set_req(0, Alu_Add, 32'd1, 32'd1, 1'b0);
        set_req(1, Alu_Add, 32'd2, 32'd2, 1'b0);
        req_valid = 2'b11;
        exp_alt[0] = 1; exp_alt[1] = 2; exp_alt[2] = 1; exp_alt[3] = 2;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("alt_grant", 32'(req_ready), exp_alt[i]);
            tick();
        end
        req_valid = 2'b00;
        tick(); tick(); tick();
        check("alt_idle_busy", 32'(busy), 0);

        // Single op latency and flags
        set_req(0, Alu_Sub, 32'd5, 32'd3, 1'b1);
        req_valid = 2'b01; #1;
        check("single_grant", 32'(req_ready), 1);
        tick();
        req_valid = 2'b00; #1;
        check("single_lat1", 32'(rsp_valid), 0);
        check("single_busy", 32'(busy), 1);
        tick();
        check("single_valid", 32'(rsp_valid), 1);
        check("single_out", rsp_out[0], 2);
        check("single_flags", 32'(rsp_flags[0]), 1);
        check("single_flagreg", 32'(flags_out), 1);
        tick();
        check("single_drained", 32'(rsp_valid), 0);

        // Flag chaining: Rlc sees C=0 from the preceding subtract
        set_req(0, Alu_Sub, 32'd0, 32'd1, 1'b1);
        req_valid = 2'b01; #1;
        check("chain_grant1", 32'(req_ready), 1);
        tick();
        set_req(0, Alu_Rlc, 32'h8000_0001, 32'd0, 1'b0); #1;
        check("chain_hold", 32'(req_ready), 0);
        tick();
        check("chain_grant2", 32'(req_ready), 1);
        check("chain_sub_out", rsp_out[0], 32'hFFFF_FFFF);
        check("chain_sub_flags", 32'(rsp_flags[0]), 8);
        check("chain_flagreg1", 32'(flags_out), 8);
        tick();
        req_valid = 2'b00;
        tick();
        check("chain_rlc_out", rsp_out[0], 2);
        check("chain_rlc_flags", 32'(rsp_flags[0]), 1);
        check("chain_flagreg2", 32'(flags_out), 8);
        tick();

        // Backpressure on requester 1
        rsp_ready = 2'b01;
        set_req(1, Alu_Xor, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b0);
        req_valid = 2'b10; #1;
        check("bp_grant1", 32'(req_ready), 2);
        tick();
        set_req(1, Alu_And, 32'hFFFF_0000, 32'h1234_5678, 1'b0);
        set_req(0, Alu_Add, 32'd3, 32'd4, 1'b0);
        req_valid = 2'b11; #1;
        check("bp_b1", 32'(req_ready), 1);
        tick();
        check("bp_b2", 32'(req_ready), 0);
        check("bp_rsp_valid", 32'(rsp_valid), 2);
        check("bp_rsp1_out", rsp_out[1], 32'hFF00_FF00);
        held = rsp_out[1];
        tick();
        check("bp_b3", 32'(req_ready), 1);
        check("bp_rsp0_out", rsp_out[0], 7);
        check("bp_rsp1_hold3", rsp_out[1], 32'hFF00_FF00);
        tick();
        check("bp_b4", 32'(req_ready), 0);
        tick();
        check("bp_b5", 32'(req_ready), 1);
        check("bp_rsp1_stable", rsp_out[1], held);
        tick();
        rsp_ready = 2'b11; #1;
        check("bp_release", 32'(req_ready), 2);
        tick();
        req_valid = 2'b00;
        tick();
        check("bp_and_valid", 32'(rsp_valid), 2);
        check("bp_and_out", rsp_out[1], 32'h1234_0000);
        check("bp_and_flags", 32'(rsp_flags[1]), 0);

        // Drain and re-grant at the same edge; nothing lost or duplicated
        set_req(1, Alu_Or, 32'h0000_00F0, 32'h0000_0F00, 1'b0);
        req_valid = 2'b10; #1;
        check("dr_grant1", 32'(req_ready), 2);
        tick();
        set_req(1, Alu_Sub, 32'd10, 32'd3, 1'b0); #1;
        check("dr_gap_valid", 32'(rsp_valid), 0);
        check("dr_in_stage", 32'(req_ready), 0);
        tick();
        check("dr_or_valid", 32'(rsp_valid), 2);
        check("dr_or_out", rsp_out[1], 32'h0000_0FF0);
        check("dr_grant2", 32'(req_ready), 2);
        tick();
        req_valid = 2'b00; #1;
        check("dr_no_dup", 32'(rsp_valid), 0);
        tick();
        check("dr_sub_valid", 32'(rsp_valid), 2);
        check("dr_sub_out", rsp_out[1], 7);
        check("dr_sub_flags", 32'(rsp_flags[1]), 1);
        tick();

        // Reset one cycle after an accept drops the op entirely
        set_req(0, Alu_Sub, 32'd9, 32'd4, 1'b1);
        req_valid = 2'b01; #1;
        check("mr_grant", 32'(req_ready), 1);
        tick();
        req_valid = 2'b00; rst = 1'b1; #1;
        check("mr_rst_rsp", 32'(rsp_valid), 0);
        tick();
        rst = 1'b0; #1;
        check("mr_busy", 32'(busy), 0);
        check("mr_flags", 32'(flags_out), 0);
        check("mr_rsp0", 32'(rsp_valid), 0);
        tick();
        check("mr_rsp1", 32'(rsp_valid), 0);
        tick();
        check("mr_rsp2", 32'(rsp_valid), 0);
        set_req(0, Alu_Add, 32'd1, 32'd2, 1'b0);
        set_req(1, Alu_Add, 32'd3, 32'd4, 1'b0);
        req_valid = 2'b11; #1;
        check("mr_tie", 32'(req_ready), 1);
        tick();
        req_valid = 2'b00;
        tick(); tick(); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_share_ctrl.md
Name: alu_share_ctrl

Overview:
- Shares the single combinational Alu between two requesters: requester 0 is the execute unit, requester 1 is the address/aux unit.
- Each requester presents a pkg_cpu::StrcInAlu-style request (a, b, oper) through a valid/ready handshake; the block arbitrates round-robin and runs one op per cycle through a registered issue stage.
- Each result returns to its owner through a one-entry response buffer.
- The block owns the CPU-visible flags register, feeds it to the Alu flags_in and updates it on request.

Parameters:
- WORD_WIDTH, `CPU_WORD_WIDTH (32): operand/result width.
- OPER_WIDTH, `CPU_ENUM_ALU_OPER_SIZE_MSB_POS+1: ALU opcode width.
- FLAGS_WIDTH, 4: flags width; bit positions follow pkg_cpu FlagN/FlagV/FlagZ/FlagC.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  [1:0]  request valid, per requester.
- req_ready  out  [1:0]  request accepted this cycle (one-hot or zero).
- req_a  in  [1:0][WORD_WIDTH]  operand A.
- req_b  in  [1:0][WORD_WIDTH]  operand B.
- req_oper  in  [1:0][OPER_WIDTH]  ALU opcode (pkg_cpu Alu_* enum).
- req_upd_flags  in  [1:0]  1 = write ALU flags_out into the flags register.
- rsp_valid  out  [1:0]  response buffer k holds a result.
- rsp_ready  in  [1:0]  requester k consumes its response.
- rsp_out  out  [1:0][WORD_WIDTH]  result.
- rsp_flags  out  [1:0][FLAGS_WIDTH]  ALU flags_out for that op, returned whether or not the flags register was updated.
- flags_out  out  FLAGS_WIDTH  current flags register.
- busy  out  1  issue stage valid or either response buffer valid.

Behaviour:
- Reset: one clock, synchronous, active-high. At the rst edge:
  - issue stage valid, both response buffers valid and flags register clear to 0.
  - last_grant is set to 1, so requester 0 wins the first tie.
  - All data registers clear to 0.
  - While rst is high, req_ready=0 and rsp_valid=0.
  - Reset mid-operation drops in-flight and buffered ops with no response.
- Eligibility: elig[k] = req_valid[k] && !(stage_valid && stage_owner==k) && !(buf_valid[k] && !rsp_ready[k]).
  - This allows at most one outstanding op per requester.
- Arbitration (combinational):
  - Only one eligible: it is granted.
  - Both eligible: grant to !last_grant.
  - req_ready = one-hot grant.
  - last_grant updates only on an actual grant.
- Issue stage (accept edge N): latch a, b, oper, upd_flags and owner; stage_valid=1 for cycle N+1.
- Execute (cycle N+1):
  - Alu inputs = stage a/b/oper, with flags_in = the current flags register, sampled at execute and not at accept.
  - At edge N+1: buf[owner] <= {Alu out, flags_out}, buf_valid[owner]=1.
  - If upd_flags, the flags register <= Alu flags_out at the same edge.
  - The next execute therefore sees the updated flags (back-to-back Rlc/Rrc chains correct).
- Latency: accept edge to rsp_valid high = 2 cycles.
  - Aggregate throughput 1 op/cycle when both requesters interleave; 1 op per 2 cycles per single requester.
- Response buffer:
  - Holds until rsp_valid && rsp_ready.
  - Drain and refill at the same edge is legal: the stage result overwrites and valid stays 1.
  - rsp_out/rsp_flags are stable while valid && !ready.
- Stage empty: the Alu is driven with zeros and no state changes.
- Widths: no width conversion; all results are the ALU's WORD_WIDTH, with carry/overflow only via flags.

Decomposition:
- pkg_cpu holds:
  - StrcInAlu, StrcOutAlu and the Alu_* enum (existing).
  - New StrcAluReq {a, b, oper, upd_flags} and StrcAluRsp {out, flags}.
  - Localparam ALU_NUM_REQ = 2.
- Sub-modules:
  - rr_arb2 (elig[1:0], last_grant -> grant[1:0]) is the one natural sub-module.
  - Alu is instantiated inside alu_share_ctrl.

Test Plan:
- Single op: req0 Alu_Sub a=5 b=3 upd=1 -> rsp_valid[0] exactly 2 cycles after accept, rsp_out=2, flags C=1 Z=0 N=0 V=0, flags_out matches next cycle.
- Tie: both valid on the first cycle after reset, req0 Sub 7-7, req1 Alu_Rol 0x80000001 by 4 -> grant order req0 then req1.
  - rsp0 = 0, Z=1, C=1.
  - rsp1 = 0x00000018.
  - Sustained contention alternates grants 0,1,0,1.
- Flags chaining: req0 Sub 0-1 upd=1 then Alu_Rlc b=0 upd=0 -> second op sees C=0 from the first.
  - flags_out is unchanged by the second op.
  - rsp_flags of the second op is still the Rlc flags.
- Backpressure: hold rsp_ready[1]=0 with req1 continuously valid -> req_ready[1] stays 0 and rsp_out[1] stays stable.
  - req0 keeps issuing 1 per 2 cycles.
  - Releasing rsp_ready[1] gives the next req1 grant in the same cycle.
- Reset mid-flight: assert rst one cycle after accepting req0 Sub 9-4 upd=1 -> no rsp_valid ever, flags_out=0, busy=0 after the edge, next tie goes to req0.
- Drain+refill: req1 buffer valid, rsp_ready[1]=1 while a req1 op is in the stage -> at the edge rsp_valid[1] stays 1 with the new result; no result is lost or duplicated.
